fetch_unit: RTL

Instruction-fetch stage of the multicycle MIPS core. Holds the program counter, drives it to the PC incrementer, and takes the incremented value back as the sequential next PC. Runs a request/acknowledge handshake with instruction memory, latches the returned word into the instruction register, and hands it to the control FSM. Applies branch/jump redirects.

---
 rtl/fetch_unit_if.sv | 30 +++
 rtl/fetch_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory request/acknowledge bus between the fetch stage and
// instruction memory.
//   imem_req    fetch request, level, held until acknowledged
//   imem_addr   word address of the request (0 while idle)
//   imem_ack    one-cycle acknowledge; imem_rdata valid in that cycle
//   imem_rdata  instruction word returned by memory
// Modports: master = fetch unit, slave = instruction memory.
// -----------------------------------------------------------------------------
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage of the multicycle MIPS core. Holds the PC, feeds it
// to the external incrementer and takes pc + 1 back, fetches the word at pc
// over a req/ack handshake, latches it into ir and hands it to the control FSM.
// Branch/jump redirects arriving mid-fetch or while ir is held are remembered
// and applied at the next PC update.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   pc            current PC (drives the incrementer)
//   pc_plus1      incrementer output
//   stall         holds the unit in IDLE
//   redirect      one-cycle branch/jump pulse, target on redirect_pc
//   imem          instruction-memory bus (fetch_unit_if.master)
//   ir, ir_valid  instruction register and its valid flag
//   ir_consume    control FSM has taken ir; advance PC
//   fetch_err     sticky fetch-timeout flag
//
// Optional feature: define FETCH_TIMEOUT_EN to add a fetch timeout. After
// TIMEOUT_CYCLES FETCH cycles without ack the unit enters ERR, raises
// fetch_err and stays there until rst. Without it fetch_err is tied to 0.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    output logic [31:0]         pc,
    input  logic [31:0]         pc_plus1,
    input  logic                stall,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    fetch_unit_if.master        imem,
    output logic [31:0]         ir,
    output logic                ir_valid,
    input  logic                ir_consume,
    output logic                fetch_err
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
`ifdef FETCH_TIMEOUT_EN
        , ERR
`endif
    } state_t;

    state_t      state_q, state_d;
    logic        pend_q;
    logic [31:0] pend_pc_q;

    // Decoded from the state register only: no input-to-output path.
    assign imem.imem_req  = (state_q == FETCH);
    assign imem.imem_addr = (state_q == FETCH) ? pc : 32'h0000_0000;

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt_q;
    logic          timeout_hit;

    // Last no-ack FETCH cycle before the limit is reached.
    assign timeout_hit = (state_q == FETCH) && !imem.imem_ack &&
                         (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
`endif

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    // Reset is synchronous: it is only seen inside the clocked block.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    // NOTE: state_d gets its default before the case so no path leaves it
    // unassigned; otherwise a latch would be inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!stall) state_d = FETCH;
            FETCH: begin
                if (imem.imem_ack)
                    state_d = (pend_q || redirect) ? IDLE : HOLD;
`ifdef FETCH_TIMEOUT_EN
                else if (timeout_hit)
                    state_d = ERR;
`endif
            end
            HOLD:  if (ir_consume) state_d = FETCH;
`ifdef FETCH_TIMEOUT_EN
            ERR:   state_d = ERR;
`endif
            default: state_d = IDLE;
        endcase
    end

    // PC, instruction register and pending-redirect bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            ir        <= 32'h0000_0000;
            ir_valid  <= 1'b0;
            pend_q    <= 1'b0;
            pend_pc_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                IDLE: if (redirect) pc <= redirect_pc;
                FETCH: begin
                    if (imem.imem_ack) begin
                        // A redirect seen during this fetch makes the word
                        // stale: drop it and restart from the newest target.
                        if (redirect) begin
                            pc     <= redirect_pc;
                            pend_q <= 1'b0;
                        end else if (pend_q) begin
                            pc     <= pend_pc_q;
                            pend_q <= 1'b0;
                        end else begin
                            ir       <= imem.imem_rdata;
                            ir_valid <= 1'b1;
                        end
                    end else if (redirect) begin
                        pend_q    <= 1'b1;
                        pend_pc_q <= redirect_pc;
                    end
                end
                HOLD: begin
                    if (ir_consume) begin
                        ir_valid <= 1'b0;
                        pend_q   <= 1'b0;
                        // Priority: live redirect, then remembered target,
                        // then the sequential PC from the incrementer.
                        if (redirect)    pc <= redirect_pc;
                        else if (pend_q) pc <= pend_pc_q;
                        else             pc <= pc_plus1;
                    end else if (redirect) begin
                        pend_q    <= 1'b1;
                        pend_pc_q <= redirect_pc;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q    <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (state_d == FETCH && state_q != FETCH)
                tcnt_q <= '0;
            else if (state_q == FETCH && !imem.imem_ack && !timeout_hit)
                tcnt_q <= tcnt_q + 1'b1;
            if (timeout_hit)
                fetch_err <= 1'b1;
        end
    end
`else
    assign fetch_err = 1'b0;
`endif

endmodule
